stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Eight-digit BCD stopwatch (HH MM SS cc) that produces the 32-bit digit word consumed by the seven-segment dynamic scan stage. Digit n of the output drives the display position selected by AN[n], so digit 7 is leftmost. The block debounces the front-panel buttons, divides the board clock to a centisecond tick, and runs a cascaded BCD counter with rollover at 24 h.

## Interface
- CLK_HZ, 100_000_000: board clock frequency.
- TICK_HZ, 100: count rate (centiseconds). DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- DB_CYCLES, 1_000_000: clocks a synchronized button level must stay stable before it is accepted.

Ports:
- clk  in  1  board clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw button; each accepted press toggles run/stop.
- btn_clear  in  1  raw button; an accepted press zeroes the time.
- btn_lap  in  1  raw button; used only with STOPWATCH_LAP_EN.
- digits  out  32  {H1,H0,M1,M0,S1,S0,C1,C0}, 4-bit BCD each; [31:28]=H1, [3:0]=C0.
- running  out  1  1 while counting.
- frozen  out  1  1 while the lap display is held; constant 0 without STOPWATCH_LAP_EN.

## Operation
- Button path (same for each button):
  - 2-flop synchronizer.
  - Stability counter that accepts a new level after DB_CYCLES consecutive equal samples.
  - Accepted level register.
  - Press event = one-clock pulse on a 0→1 transition of the accepted level. Release produces no event.
- Run control: on a start event, running toggles.
- Prescaler: counts 0..DIV-1 only while running. It holds its value while stopped, so a resumed count continues the partial period. tick is high for one clock when the prescaler equals DIV-1 and running=1.
- Time counter on tick:
  - C0 increments 0..9; each digit carries into the next.
  - Limits: C1 0..9, S0 0..9, S1 0..5, M0 0..9, M1 0..5, H1:H0 00..23.
  - 23:59:59.99 + tick → 00:00:00.00; running stays 1.
- Clear event: time and prescaler go to 0 and running is unchanged. If clear and tick occur in the same clock, clear wins and the result is all zeros.
- Start and clear in the same clock: both take effect (toggle plus zero).
- digits is the registered time value, or the frozen copy (see Configuration).
- Digits never hold non-BCD values. Every digit is always ≤ 9 and within its limit above.

## Timing
- Reset values:
  - digits = 32'h0000_0000, running = 0, frozen = 0.
  - Prescaler, debounce counters and synchronizers all 0.
  - Accepted button levels 0.
- Press latency: a clean raw edge produces the event pulse exactly DB_CYCLES+3 clocks after the edge is first sampled. Any raw level held for fewer than DB_CYCLES clocks produces no event.
- Start event at clock t: running = 1 from t+1. The first tick occurs DIV clocks later when starting from prescaler = 0.
- tick at clock t: the updated digits are visible at t+1.
- A clear event at t: digits = 0 at t+1.
- rst asserted mid-count: all state returns to reset values immediately, independent of clk. Counting resumes only after release and a new start press.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap event toggles frozen.
  - While frozen = 1, digits holds the time captured in the clock of the lap event, while the internal count continues.
  - On unfreeze, digits shows the live time at t+1.
  - A clear event forces frozen = 0 and digits = 0.
  - A lap event while running = 0 and frozen = 0 is ignored.
- STOPWATCH_LAP_EN undefined:
  - btn_lap is unused, frozen is tied to 0 and digits always shows the live time.
  - No lap registers are synthesized.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DB_CYCLES=4.

- Reset, then a start press held 20 clocks → running = 1 at event+1; after 10 ticks digits = 32'h0000_0010; after 100 ticks digits = 32'h0000_0100.
- Start press glitches: high for 3 clocks, then low → no event and running stays 0. A 5-clock pulse → exactly one toggle.
- Preload via ticks to 32'h2359_5999, then one tick → digits = 32'h0000_0000, running = 1. Also check 32'h0000_5999 → 32'h0001_0000.
- Stop at prescaler = 6, wait 50 clocks, restart → next tick arrives 3 clocks after running = 1. Clear coincident with tick → digits = 0.
- LAP_EN build: lap at digits = 32'h0000_0123, wait 30 ticks → digits stays 32'h0000_0123 and frozen = 1. Second lap → digits = 32'h0000_0153. Clear while frozen → frozen = 0, digits = 0.
- Assert rst asynchronously mid-count between clock edges → digits = 0, running = 0 before the next edge.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// Eight-digit BCD stopwatch (HH MM SS cc) with debounced front-panel buttons.
// Define STOPWATCH_LAP_EN to enable the lap/freeze display via btn_lap.
module stopwatch_bcd #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [31:0] digits,
    output logic        running,
    output logic        frozen
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    // Per-digit wrap values, C0 first; hours are handled separately.
    localparam logic [5:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NB = 3;
`else
    localparam int unsigned NB = 2;
`endif

    logic [NB-1:0] raw;
    logic [NB-1:0] ev;
`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_clear, btn_start};
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign raw        = {btn_clear, btn_start};
`endif

    // Synchronize, debounce and edge-detect each button.
    for (genvar g = 0; g < NB; g++) begin : g_btn
        logic           s1, s2, lvl, lvl_d, evq;
        logic [DBW-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                evq   <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= raw[g];
                s2    <= s1;
                lvl_d <= lvl;
                evq   <= lvl & ~lvl_d;
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DB_CYCLES)) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DBW'(1);
                end
            end
        end
        assign ev[g] = evq;
    end

    logic                ev_start, ev_clear, tick_c, carry, run_nxt;
    logic [PW-1:0]       pre, pre_nxt;
    logic [7:0][3:0]     tm, tm_inc, tm_nxt;

    assign ev_start = ev[0];
    assign ev_clear = ev[1];
    assign tick_c   = running && (pre == PW'(DIV - 1));

    // Cascaded BCD increment with 23:59:59.99 -> 00:00:00.00 wrap.
    always_comb begin
        tm_inc = tm;
        carry  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (tm[i] == LIM[i]) begin
                    tm_inc[i] = 4'd0;
                end else begin
                    tm_inc[i] = tm[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        if (carry) begin
            if (tm[7] == 4'd2 && tm[6] == 4'd3) begin
                tm_inc[7] = 4'd0;
                tm_inc[6] = 4'd0;
            end else if (tm[6] == 4'd9) begin
                tm_inc[7] = tm[7] + 4'd1;
                tm_inc[6] = 4'd0;
            end else begin
                tm_inc[6] = tm[6] + 4'd1;
            end
        end
    end

    // Clear dominates a coincident tick; start toggles independently.
    always_comb begin
        run_nxt = running ^ ev_start;
        pre_nxt = pre;
        tm_nxt  = tm;
        if (ev_clear) begin
            pre_nxt = '0;
            tm_nxt  = '0;
        end else if (running) begin
            pre_nxt = tick_c ? '0 : pre + PW'(1);
            if (tick_c) tm_nxt = tm_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            pre     <= '0;
            tm      <= '0;
        end else begin
            running <= run_nxt;
            pre     <= pre_nxt;
            tm      <= tm_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        frozen_nxt;
    logic [31:0] disp;

    always_comb begin
        frozen_nxt = frozen;
        if (ev_clear) frozen_nxt = 1'b0;
        else if (ev[2] && (running || frozen)) frozen_nxt = ~frozen;
    end

    // Display holds the time seen in the lap-event clock while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frozen <= 1'b0;
            disp   <= '0;
        end else begin
            frozen <= frozen_nxt;
            if (!frozen_nxt) disp <= tm_nxt;
            else if (!frozen) disp <= tm;
        end
    end

    assign digits = disp;
`else
    assign frozen = 1'b0;
    assign digits = tm;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: expectations are queued by cycle and
// checked by an independent monitor on the falling clock edge.
module tb_stopwatch_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap = 1'b0;
    logic [31:0] digits;
    logic        running;
    logic        frozen;

    stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .digits    (digits),
        .running   (running),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] dig;
        logic        run;
        logic        frz;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int at, input logic [31:0] d, input logic r,
                             input logic f, input string nm);
        exp_t e;
        int   idx;
        e.at = at; e.dig = d; e.run = r; e.frz = f; e.name = nm;
        idx = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].at > at) begin
                idx = i;
                break;
            end
        end
        sbq.insert(idx, e);
    endtask

    task automatic check(input string nm, input logic [31:0] d, input logic r, input logic f);
        checks++;
        if (digits !== d || running !== r || frozen !== f) begin
            errors++;
            $display("FAIL %s @cyc %0d: got digits=%h running=%b frozen=%b, want digits=%h running=%b frozen=%b",
                     nm, cyc, digits, running, frozen, d, r, f);
        end
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            mon_e = sbq.pop_front();
            if (mon_e.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", mon_e.name, mon_e.at, cyc);
            end else begin
                check(mon_e.name, mon_e.dig, mon_e.run, mon_e.frz);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_start = v;
            1:       btn_clear = v;
            default: btn_lap   = v;
        endcase
    endtask

    task automatic press(input int which, input int at, input int len);
        wait_cyc(at);
        set_btn(which, 1'b1);
        wait_cyc(at + len);
        set_btn(which, 1'b0);
    endtask

    task automatic preload(input int at, input logic [31:0] v);
        wait_cyc(at);
        #2 force dut.tm = v;
        #1 release dut.tm;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, idle lap ignored, 3-clock start glitch ignored.
        expect_at(2,    32'h0000_0000, 1'b0, 1'b0, "reset_state");
        expect_at(16,   32'h0000_0000, 1'b0, 1'b0, "lap_idle_ignored");
        expect_at(40,   32'h0000_0000, 1'b0, 1'b0, "start_glitch");
        // Start press at 50: event at 58, running from 59, ticks update at 59+10k.
        expect_at(58,   32'h0000_0000, 1'b0, 1'b0, "start_latency_before");
        expect_at(59,   32'h0000_0000, 1'b1, 1'b0, "start_latency");
        expect_at(68,   32'h0000_0000, 1'b1, 1'b0, "first_tick_before");
        expect_at(69,   32'h0000_0001, 1'b1, 1'b0, "first_tick");
        expect_at(158,  32'h0000_0009, 1'b1, 1'b0, "tick_9");
        expect_at(159,  32'h0000_0010, 1'b1, 1'b0, "tick_10");
        expect_at(1059, 32'h0000_0100, 1'b1, 1'b0, "tick_100");
        expect_at(1068, 32'h0000_5999, 1'b1, 1'b0, "minute_carry_before");
        expect_at(1069, 32'h0001_0000, 1'b1, 1'b0, "minute_carry");
        expect_at(1078, 32'h2359_5999, 1'b1, 1'b0, "day_wrap_before");
        expect_at(1079, 32'h0000_0000, 1'b1, 1'b0, "day_wrap");
        expect_at(1089, 32'h0000_0001, 1'b1, 1'b0, "after_wrap");
        // 5-clock stop pulse at 1096 with prescaler landing on 6.
        expect_at(1104, 32'h0000_0002, 1'b1, 1'b0, "stop_before");
        expect_at(1105, 32'h0000_0002, 1'b0, 1'b0, "stop");
        expect_at(1150, 32'h0000_0002, 1'b0, 1'b0, "stopped_hold");
        // Restart at 1159: running at 1168, tick 3 clocks later.
        expect_at(1167, 32'h0000_0002, 1'b0, 1'b0, "restart_before");
        expect_at(1168, 32'h0000_0002, 1'b1, 1'b0, "restart");
        expect_at(1171, 32'h0000_0002, 1'b1, 1'b0, "resume_partial_before");
        expect_at(1172, 32'h0000_0003, 1'b1, 1'b0, "resume_partial");
        // Clear at 1193 lands on the tick cycle 1201.
        expect_at(1201, 32'h0000_0005, 1'b1, 1'b0, "clear_tick_before");
        expect_at(1202, 32'h0000_0000, 1'b1, 1'b0, "clear_wins_tick");
        expect_at(1211, 32'h0000_0000, 1'b1, 1'b0, "clear_prescaler_before");
        expect_at(1212, 32'h0000_0001, 1'b1, 1'b0, "clear_prescaler");
        expect_at(2434, 32'h0000_0123, 1'b1, 1'b0, "lap1_before");
`ifdef STOPWATCH_LAP_EN
        expect_at(2435, 32'h0000_0123, 1'b1, 1'b1, "lap_freeze");
        expect_at(2733, 32'h0000_0123, 1'b1, 1'b1, "lap_hold_30_ticks");
        expect_at(2734, 32'h0000_0153, 1'b1, 1'b0, "lap_unfreeze");
        expect_at(2754, 32'h0000_0155, 1'b1, 1'b1, "lap_refreeze");
        expect_at(2763, 32'h0000_0155, 1'b1, 1'b1, "lap_refreeze_hold");
        expect_at(2773, 32'h0000_0155, 1'b1, 1'b1, "clear_frozen_before");
`else
        expect_at(2435, 32'h0000_0123, 1'b1, 1'b0, "lap_no_effect");
        expect_at(2733, 32'h0000_0153, 1'b1, 1'b0, "live_30_ticks");
        expect_at(2734, 32'h0000_0153, 1'b1, 1'b0, "lap_no_effect2");
        expect_at(2754, 32'h0000_0155, 1'b1, 1'b0, "lap_no_effect3");
        expect_at(2763, 32'h0000_0156, 1'b1, 1'b0, "live_tick");
        expect_at(2773, 32'h0000_0157, 1'b1, 1'b0, "clear2_before");
`endif
        expect_at(2774, 32'h0000_0000, 1'b1, 1'b0, "clear_frozen");
        expect_at(2783, 32'h0000_0000, 1'b1, 1'b0, "after_clear_before");
        expect_at(2784, 32'h0000_0001, 1'b1, 1'b0, "after_clear");
        expect_at(2830, 32'h0000_0000, 1'b0, 1'b0, "no_resume_after_reset");

        wait_cyc(3);
        rst = 1'b0;
        press(2, 5, 6);
        press(0, 20, 3);
        press(0, 50, 20);
        preload(1059, 32'h0000_5999);
        preload(1069, 32'h2359_5999);
        press(0, 1096, 5);
        press(0, 1159, 20);
        press(1, 1193, 6);
        press(2, 2426, 6);
        press(2, 2725, 6);
        press(2, 2745, 6);
        press(1, 2765, 6);

        // Asynchronous reset between edges must take effect before the next edge.
        wait_cyc(2790);
        #2 rst = 1'b1;
        #1 check("async_reset", 32'h0000_0000, 1'b0, 1'b0);
        wait_cyc(2795);
        rst = 1'b0;

        wait_cyc(2835);
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never checked", mon_e.name, mon_e.at);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
